param_shift_register: RTL and testbench

- Parametrised successor to the single-bit clearable D flip-flop: a WIDTH-bit register with asynchronous active-low clear and a multi-cycle shift/rotate engine.
- A start request loads the register, or shifts/rotates it by a programmable amount at one bit per clock.
- The end of every operation is reported with a one-cycle done pulse.
- Used as the general-purpose storage/serialiser element for the lab datapaths.

---
 rtl/shreg_pkg.sv | 25 ++
 rtl/shreg_step.sv | 26 ++
 rtl/param_shift_register.sv | 105 ++++++++++
 tb/tb_param_shift_register.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared types for the parametrised shift register: operation codes and FSM states.
// Op codes 6 and 7 are reserved and behave as no-ops.
package shreg_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_SHL  = 3'd1,
        OP_SHR  = 3'd2,
        OP_SAR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True for the ops that run through the multi-cycle SHIFT state.
    function automatic logic is_step_op(input logic [2:0] op);
        return (op >= OP_SHL) && (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/shreg_step.sv
// Purely combinational single-step function: one shift or rotate of q by one bit.
// LOAD and reserved codes pass q through unchanged.
module shreg_step
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic             sin,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (op)
            OP_SHL:  q_next = {q[WIDTH-2:0], sin};
            OP_SHR:  q_next = {sin, q[WIDTH-1:1]};
            OP_SAR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/param_shift_register.sv
// WIDTH-bit register with async clear, parallel load and a one-bit-per-clock shift/rotate engine.
// Optional synchronous clear input sclr is present when SYNC_CLR_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; LOAD / no-op requests complete on one edge
// ST_SHIFT | one step of the latched op per edge, counter counts down
// ST_DONE  | single-cycle done pulse, then back to ST_IDLE
module param_shift_register
    import shreg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
)(
    input  logic             clk,
    input  logic             CLRN,
`ifdef SYNC_CLR_EN
    input  logic             sclr,
`endif
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, step_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;

    shreg_step #(.WIDTH(WIDTH)) u_step (
        .q      (q_q),
        .op     (op_q),
        .sin    (sin),
        .q_next (step_q)
    );

    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // LOAD, reserved codes and zero-length shifts all finish on this edge.
                    state_d = ST_DONE;
                    if (op == OP_LOAD) begin
                        q_d = D;
                    end else if (is_step_op(op) && (amount != '0)) begin
                        op_d    = op;
                        cnt_d   = amount;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                q_d   = step_q;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef SYNC_CLR_EN
        // Synchronous clear wins over any request or step in progress.
        if (sclr) begin
            q_d     = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end
`endif
    end

    assign Q    = q_q;
    assign nQ   = ~q_q;
    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_param_shift_register.sv
// Scoreboard bench for param_shift_register: stimulus pushes expected results, a monitor checks on done.
// Exercises the sclr path as well when SYNC_CLR_EN is defined.
module tb_param_shift_register;

    localparam int W     = 8;
    localparam int CNT_W = $clog2(W) + 1;

    logic             clk = 1'b0;
    logic             CLRN;
    logic             sclr;
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] amount;
    logic [W-1:0]     D;
    logic             sin;
    logic [W-1:0]     Q;
    logic [W-1:0]     nQ;
    logic             busy;
    logic             done;

    param_shift_register #(.WIDTH(W)) dut (
        .clk    (clk),
        .CLRN   (CLRN),
`ifdef SYNC_CLR_EN
        .sclr   (sclr),
`endif
        .start  (start),
        .op     (op),
        .amount (amount),
        .D      (D),
        .sin    (sin),
        .Q      (Q),
        .nQ     (nQ),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] q;
        int           cyc;
        int           busy;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] q_model;
    int           busy_cnt = 0;
    logic         prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference result of applying op o with amount n, from the arithmetic meaning of each op.
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] q, input int o, input int n,
                                                 input logic s, input logic [W-1:0] d);
        logic [2*W-1:0] wide;
        logic [W-1:0]   fill;
        int             k;
        if (o == 0) return d;
        if (o > 5 || n == 0) return q;
        fill = s ? '1 : '0;
        case (o)
            1: return (n >= W) ? fill : ((q << n) | (fill >> (W - n)));
            2: return (n >= W) ? fill : ((q >> n) | (fill << (W - n)));
            3: return W'($signed(q) >>> n);
            4: begin
                k    = n % W;
                wide = {q, q} << k;
                return wide[2*W-1:W];
            end
            default: begin
                k    = n % W;
                wide = {q, q} >> k;
                return wide[W-1:0];
            end
        endcase
    endfunction

    // Monitor: pops the scoreboard whenever done is presented.
    always @(negedge clk) begin
        if (!CLRN) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            check("nq_is_inverse", 32'(Q ^ nQ), 32'hFF);
            if (busy && done) check("busy_done_exclusive", 32'(busy & done), 32'd0);
            if (busy) busy_cnt++;
            else if (!done) busy_cnt = 0;
            if (done) begin
                check("done_one_cycle", 32'(prev_done), 32'd0);
                check("done_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_q", 32'(Q), 32'(e.q));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
                end
                busy_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic do_op(input int o, input int n, input logic [W-1:0] d, input logic s, input bit noise);
        logic [W-1:0] q0, fin;
        int           steps;
        exp_t         e;
        q0    = q_model;
        fin   = ref_result(q0, o, n, s, d);
        steps = (o >= 1 && o <= 5) ? n : 0;
        @(negedge clk);
        start  = 1'b1;
        op     = 3'(o);
        amount = CNT_W'(n);
        D      = d;
        sin    = s;
        e.q    = fin;
        e.cyc  = cyc + 1 + steps;
        e.busy = steps;
        sb.push_back(e);
        for (int j = 0; j <= steps; j++) begin
            @(negedge clk);
            if (noise) begin
                start  = 1'($urandom);
                op     = 3'($urandom);
                amount = CNT_W'($urandom);
                D      = W'($urandom);
            end else begin
                start = 1'b0;
            end
            check("q_step", 32'(Q), 32'((steps == 0) ? fin : ref_result(q0, o, j, s, d)));
        end
        q_model = fin;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_q"}, 32'(Q), 32'd0);
        check({tag, "_nq"}, 32'(nQ), 32'hFF);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        CLRN = 1'b0; sclr = 1'b0; start = 1'b0; op = '0; amount = '0; D = '0; sin = 1'b0;
        q_model = '0;
        #2;
        check_cleared("reset_initial");
        @(negedge clk); #1 CLRN = 1'b1;

        do_op(0, 0, 8'hA5, 1'b0, 1'b0);

        // Async clear between edges takes effect without a clock.
        @(negedge clk);
        start = 1'b0;
        #2 CLRN = 1'b0;
        #1 check_cleared("async_clear");
        @(negedge clk); #1 CLRN = 1'b1;
        q_model = '0;

        do_op(0, 0, 8'h81, 1'b0, 1'b0);
        do_op(4, 3, 8'h00, 1'b0, 1'b1);
        do_op(0, 0, 8'h80, 1'b0, 1'b0);
        do_op(3, 9, 8'h00, 1'b0, 1'b0);
        do_op(0, 0, 8'h0F, 1'b0, 1'b0);
        do_op(1, 2, 8'h00, 1'b1, 1'b0);
        do_op(6, 3, 8'h55, 1'b0, 1'b0);
        do_op(7, 5, 8'hAA, 1'b1, 1'b0);
        do_op(5, 0, 8'h12, 1'b0, 1'b0);
        do_op(4, 8, 8'h00, 1'b0, 1'b0);
        do_op(2, 12, 8'h00, 1'b1, 1'b0);
        do_op(1, 15, 8'h00, 1'b0, 1'b0);

        // Abort a SHR by 5 after two steps; no done may follow.
        do_op(0, 0, 8'hF3, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd2; amount = CNT_W'(5); sin = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_abort_q", 32'(Q), 32'(ref_result(8'hF3, 2, 2, 1'b1, 8'h00)));
        #2 CLRN = 1'b0;
        #1 check_cleared("abort_clear");
        @(negedge clk); #1 CLRN = 1'b1;
        q_model = '0;
        repeat (8) begin
            @(negedge clk);
            check("post_abort_busy", 32'(busy), 32'd0);
            check("post_abort_done", 32'(done), 32'd0);
        end
        do_op(0, 0, 8'h3C, 1'b0, 1'b0);

`ifdef SYNC_CLR_EN
        do_op(0, 0, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd5; amount = CNT_W'(6); sin = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); sclr = 1'b1;
        @(negedge clk); sclr = 1'b0;
        check_cleared("sclr");
        q_model = '0;
        repeat (8) begin
            @(negedge clk);
            check("post_sclr_done", 32'(done), 32'd0);
        end
`endif

        for (int i = 0; i < 60; i++) begin
            do_op($urandom_range(0, 7), $urandom_range(0, 15), W'($urandom), 1'($urandom), 1'b1);
        end

        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
